// File: rtl/drum_sched_pkg.sv
// Shared constants, register map and types for the drum pulse scheduler.
package drum_sched_pkg;

    localparam int NUM_CH     = 6;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 16;
    localparam int ADDR_W     = 3;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    // Register word addresses
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_WIDTH    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EVENT    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 3'd4;

    // CTRL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STAT_LEVEL_LSB = 0;
    localparam int STAT_EMPTY     = 8;
    localparam int STAT_FULL      = 9;
    localparam int STAT_BUSY      = 10;
    localparam int STAT_OVERFLOW  = 11;
    localparam int STAT_DONE      = 12;

    // EVENT register: delay lives in the upper half-word
    localparam int EVT_DELAY_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FIRE
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  delay;
        logic [NUM_CH-1:0] mask;
    } drum_event_t;

endpackage

// File: rtl/drum_pulse_scheduler_if.sv
// Avalon-MM slave bus bundle for the drum pulse scheduler.
interface drum_pulse_scheduler_if;
    import drum_sched_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/drum_event_fifo.sv
// Synchronous show-ahead FIFO holding queued hit events.
module drum_event_fifo
    import drum_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  drum_event_t      wr_data,
    output drum_event_t      head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    drum_event_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(FIFO_DEPTH));
    // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr];

    // Storage write; the level counter alone tells which entries are valid.
    // NOTE: the storage array is deliberately not reset -- only pointers and level need it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and level bookkeeping, with flush emptying the queue.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/drum_pulse_scheduler.sv
// Avalon-MM slave that replays queued hit events as timed pulses on out_port.
module drum_pulse_scheduler
    import drum_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    drum_pulse_scheduler_if.slave bus,
    output logic [NUM_CH-1:0]     out_port,
    output logic                  irq
);

    // Bus decode
    logic wr_en, rd_en;
    logic ctrl_wr, status_wr, width_wr, event_wr, prescale_wr, flush;
    assign wr_en       = bus.chipselect && !bus.write_n;
    assign rd_en       = bus.chipselect && !bus.read_n;
    assign ctrl_wr     = wr_en && (bus.address == ADDR_CTRL);
    assign status_wr   = wr_en && (bus.address == ADDR_STATUS);
    assign width_wr    = wr_en && (bus.address == ADDR_WIDTH);
    assign event_wr    = wr_en && (bus.address == ADDR_EVENT);
    assign prescale_wr = wr_en && (bus.address == ADDR_PRESCALE);
    assign flush       = ctrl_wr && bus.writedata[CTRL_FLUSH];

    // Only some write-data bits are mapped; fold the rest away explicitly.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // Register file and FSM state
    logic             enable_q, irq_en_q, overflow_q, done_q;
    logic [CNT_W-1:0] width_q, prescale_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] pre_lat_q, pre_lat_d;
    logic [NUM_CH-1:0] mask_q, mask_d, out_d;
    logic             pop, done_set, ovf_set, tick;
    logic [CNT_W-1:0] eff_width;

    // Event queue
    drum_event_t      evt_in, head;
    logic [LVL_W-1:0] level;
    logic             fifo_full, fifo_empty;
    assign evt_in = {bus.writedata[EVT_DELAY_LSB +: CNT_W], bus.writedata[NUM_CH-1:0]};

    drum_event_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (event_wr),
        .pop     (pop),
        .flush   (flush),
        .wr_data (evt_in),
        .head    (head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ovf_set   = event_wr && fifo_full && !pop && !flush;
    assign tick      = (pre_cnt_q == pre_lat_q);
    assign eff_width = (width_q == '0) ? CNT_W'(1) : width_q;

    // Next-state logic: pop in IDLE, count delay ticks in WAIT, count width ticks in FIRE.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        width_cnt_d = width_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        pre_lat_d   = pre_lat_q;
        mask_d      = mask_q;
        out_d       = out_port;
        pop         = 1'b0;
        done_set    = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            delay_cnt_d = '0;
            width_cnt_d = '0;
            pre_cnt_d   = '0;
            pre_lat_d   = '0;
            out_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_q && !fifo_empty) begin
                        pop       = 1'b1;
                        mask_d    = head.mask;
                        pre_cnt_d = '0;
                        pre_lat_d = prescale_q;
                        if (head.delay == '0) begin
                            state_d     = FIRE;
                            out_d       = head.mask;
                            width_cnt_d = eff_width;
                        end else begin
                            state_d     = WAIT;
                            delay_cnt_d = head.delay;
                        end
                    end
                end
                WAIT: begin
                    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
                    if (tick) begin
                        delay_cnt_d = delay_cnt_q - 1'b1;
                        if (delay_cnt_q == CNT_W'(1)) begin
                            state_d     = FIRE;
                            out_d       = mask_q;
                            width_cnt_d = eff_width;
                            pre_lat_d   = prescale_q;
                        end
                    end
                end
                FIRE: begin
                    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
                    if (tick) begin
                        width_cnt_d = width_cnt_q - 1'b1;
                        if (width_cnt_q == CNT_W'(1)) begin
                            state_d  = IDLE;
                            out_d    = '0;
                            done_set = fifo_empty;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, counters and the registered drum outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            delay_cnt_q <= '0;
            width_cnt_q <= '0;
            pre_cnt_q   <= '0;
            pre_lat_q   <= '0;
            mask_q      <= '0;
            out_port    <= '0;
        end else begin
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            width_cnt_q <= width_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            pre_lat_q   <= pre_lat_d;
            mask_q      <= mask_d;
            out_port    <= out_d;
        end
    end

    // Software-visible registers, sticky flags (set wins over W1C) and the irq flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            width_q    <= '0;
            prescale_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_q <= bus.writedata[CTRL_ENABLE];
                irq_en_q <= bus.writedata[CTRL_IRQ_EN];
            end
            if (width_wr)    width_q    <= bus.writedata[CNT_W-1:0];
            if (prescale_wr) prescale_q <= bus.writedata[CNT_W-1:0];
            if (status_wr && bus.writedata[STAT_OVERFLOW]) overflow_q <= 1'b0;
            if (ovf_set)                                   overflow_q <= 1'b1;
            if (status_wr && bus.writedata[STAT_DONE])     done_q     <= 1'b0;
            if (done_set)                                  done_q     <= 1'b1;
            irq <= irq_en_q && done_q;
        end
    end

    // Zero-latency read mux; unmapped addresses and idle cycles return 0.
    always_comb begin
        bus.readdata = '0;
        if (rd_en) begin
            case (bus.address)
                ADDR_CTRL: begin
                    bus.readdata[CTRL_ENABLE] = enable_q;
                    bus.readdata[CTRL_IRQ_EN] = irq_en_q;
                end
                ADDR_STATUS: begin
                    bus.readdata[STAT_LEVEL_LSB +: LVL_W] = level;
                    bus.readdata[STAT_EMPTY]    = fifo_empty;
                    bus.readdata[STAT_FULL]     = fifo_full;
                    bus.readdata[STAT_BUSY]     = (state_q != IDLE);
                    bus.readdata[STAT_OVERFLOW] = overflow_q;
                    bus.readdata[STAT_DONE]     = done_q;
                end
                ADDR_WIDTH:    bus.readdata[CNT_W-1:0] = width_q;
                ADDR_PRESCALE: bus.readdata[CNT_W-1:0] = prescale_q;
                default:       bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_drum_pulse_scheduler.sv
// Self-checking bench: register vector table plus hand-written timing sequences.
module tb_drum_pulse_scheduler;
    import drum_sched_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] out_port;
    logic              irq;

    drum_pulse_scheduler_if bus ();

    drum_pulse_scheduler dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_wr;
        logic [2:0]   addr;
        logic [31:0]  data;
        logic [31:0]  exp;
        int           rep;
        string        name;
    } vec_t;

    vec_t              vecs[$];
    int                n_vec = 0;
    int                n_err = 0;
    logic [NUM_CH-1:0] tr_out [256];
    logic              tr_irq [256];
    logic [31:0]       rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One write cycle: driven at a falling edge, captured at the next rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Combinational read; takes no clock edge.
    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = a;
        #1 d = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    // Record out_port/irq at n consecutive falling edges, starting now.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr_out[i] = out_port;
            tr_irq[i] = irq;
            @(negedge clk);
        end
    endtask

    function automatic int run_len(input int start, input logic [NUM_CH-1:0] val);
        int n = 0;
        for (int i = start; i < 256 && tr_out[i] == val; i++) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.address    = '0;
        bus.writedata  = '0;

        // Register-level vectors: reset values, R/W masking, overflow and flush.
        vecs.push_back('{1'b0, ADDR_STATUS,   32'h0,         32'h0000_0100, 1, "rst_status"});
        vecs.push_back('{1'b0, ADDR_CTRL,     32'h0,         32'h0,         1, "rst_ctrl"});
        vecs.push_back('{1'b0, ADDR_WIDTH,    32'h0,         32'h0,         1, "rst_width"});
        vecs.push_back('{1'b0, ADDR_PRESCALE, 32'h0,         32'h0,         1, "rst_prescale"});
        vecs.push_back('{1'b0, ADDR_EVENT,    32'h0,         32'h0,         1, "rst_event"});
        vecs.push_back('{1'b0, 3'd5,          32'h0,         32'h0,         1, "unmapped_5"});
        vecs.push_back('{1'b1, ADDR_WIDTH,    32'hFFFF_1234, 32'h0,         1, ""});
        vecs.push_back('{1'b0, ADDR_WIDTH,    32'h0,         32'h0000_1234, 1, "width_rw"});
        vecs.push_back('{1'b1, ADDR_PRESCALE, 32'hABCD_0007, 32'h0,         1, ""});
        vecs.push_back('{1'b0, ADDR_PRESCALE, 32'h0,         32'h0000_0007, 1, "prescale_rw"});
        vecs.push_back('{1'b1, ADDR_CTRL,     32'hFFFF_FFFF, 32'h0,         1, ""});
        vecs.push_back('{1'b0, ADDR_CTRL,     32'h0,         32'h0000_0005, 1, "ctrl_rw_flush_reads_0"});
        vecs.push_back('{1'b1, ADDR_CTRL,     32'h0,         32'h0,         1, ""});
        vecs.push_back('{1'b1, ADDR_EVENT,    32'h0003_0011, 32'h0,         9, ""});
        vecs.push_back('{1'b0, ADDR_STATUS,   32'h0,         32'h0000_0A08, 1, "full_overflow"});
        vecs.push_back('{1'b0, ADDR_EVENT,    32'h0,         32'h0,         1, "event_reads_0"});
        vecs.push_back('{1'b1, ADDR_STATUS,   32'h0000_0800, 32'h0,         1, ""});
        vecs.push_back('{1'b0, ADDR_STATUS,   32'h0,         32'h0000_0208, 1, "overflow_w1c"});
        vecs.push_back('{1'b1, ADDR_CTRL,     32'h0000_0002, 32'h0,         1, ""});
        vecs.push_back('{1'b0, ADDR_STATUS,   32'h0,         32'h0000_0100, 1, "flush_idle"});

        repeat (3) @(negedge clk);
        check("rst_out_port", 32'(out_port), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                for (int r = 0; r < vecs[i].rep; r++) bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                check_reg(vecs[i].name, vecs[i].addr, vecs[i].exp);
            end
        end

        // P=0, WIDTH=3, mask 0x05 delay 0: high in samples 1..3.
        bus_write(ADDR_PRESCALE, 32'd0);
        bus_write(ADDR_WIDTH, 32'd3);
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_EVENT, 32'h0000_0005);
        capture(8);
        check("p0_idle_cycle", 32'(tr_out[0]), 32'h0);
        check("p0_first_high", 32'(tr_out[1]), 32'h05);
        check("p0_pulse_len", run_len(1, 6'h05), 32'd3);
        check("p0_after_pulse", 32'(tr_out[4]), 32'h0);
        check_reg("p0_done", ADDR_STATUS, 32'h0000_1100);

        // P=9, WIDTH=2: (0x01,d=5) then (0x20,d=0), released by enable.
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_PRESCALE, 32'd9);
        bus_write(ADDR_WIDTH, 32'd2);
        bus_write(ADDR_EVENT, 32'h0005_0001);
        bus_write(ADDR_EVENT, 32'h0000_0020);
        bus_write(ADDR_STATUS, 32'h0000_1000);
        check_reg("p9_queued", ADDR_STATUS, 32'h0000_0002);
        bus_write(ADDR_CTRL, 32'h1);
        capture(100);
        check("p9_still_waiting", 32'(tr_out[50]), 32'h0);
        check("p9_first_high", 32'(tr_out[51]), 32'h01);
        check("p9_pulse1_len", run_len(51, 6'h01), 32'd20);
        check("p9_gap", 32'(tr_out[71]), 32'h0);
        check("p9_pulse2_len", run_len(72, 6'h20), 32'd20);
        check("p9_after", 32'(tr_out[92]), 32'h0);
        check_reg("p9_done", ADDR_STATUS, 32'h0000_1100);

        // enable cleared mid-event: pulse completes, second entry stays queued.
        bus_write(ADDR_STATUS, 32'h0000_1000);
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_PRESCALE, 32'd0);
        bus_write(ADDR_WIDTH, 32'd4);
        bus_write(ADDR_EVENT, 32'h0000_0009);
        bus_write(ADDR_EVENT, 32'h0000_0009);
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h0);
        capture(8);
        check("dis_pulse_rest", run_len(0, 6'h09), 32'd3);
        check("dis_no_pop", 32'(tr_out[7]), 32'h0);
        check_reg("dis_level", ADDR_STATUS, 32'h0000_0001);
        bus_write(ADDR_CTRL, 32'h2);

        // Flush during FIRE with 3 events still queued.
        bus_write(ADDR_WIDTH, 32'd10);
        for (int i = 0; i < 4; i++) bus_write(ADDR_EVENT, 32'h0000_0012);
        bus_write(ADDR_CTRL, 32'h1);
        capture(5);
        check("fl_firing", 32'(tr_out[4]), 32'h12);
        check_reg("fl_busy_level", ADDR_STATUS, 32'h0000_0403);
        bus_write(ADDR_CTRL, 32'h2);
        check("fl_out_cleared", 32'(out_port), 32'h0);
        check_reg("fl_status", ADDR_STATUS, 32'h0000_0100);

        // irq with WIDTH=0 (one tick) and W1C release.
        bus_write(ADDR_WIDTH, 32'd0);
        bus_write(ADDR_CTRL, 32'h5);
        bus_write(ADDR_EVENT, 32'h0000_003F);
        capture(6);
        check("w0_high", 32'(tr_out[1]), 32'h3F);
        check("w0_len", run_len(1, 6'h3F), 32'd1);
        check("irq_not_yet", 32'(tr_irq[2]), 32'h0);
        check("irq_rise", 32'(tr_irq[3]), 32'h1);
        bus_write(ADDR_STATUS, 32'h0000_1000);
        check("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_fall", 32'(irq), 32'h0);

        // Asynchronous reset in the middle of a pulse.
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_WIDTH, 32'd10);
        bus_write(ADDR_EVENT, 32'h0000_002A);
        capture(3);
        check("ar_firing", 32'(tr_out[2]), 32'h2A);
        #2 reset_n = 1'b0;
        #1 check("ar_out_async", 32'(out_port), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reg("ar_status", ADDR_STATUS, 32'h0000_0100);
        check_reg("ar_width", ADDR_WIDTH, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/drum_pulse_scheduler.md
# drum_pulse_scheduler

Avalon-MM slave that schedules timed drive pulses on the 6-bit drum output port of the Nios II system. Software queues hit events: a channel mask plus a delay relative to the previous hit. The block replays them with a programmable pulse width and prescaled timebase, then raises an interrupt when the queue drains. It replaces CPU bit-banging of the drum output PIO.

## Interface
- NUM_CH, 6: output channels (width of out_port and event mask)
- FIFO_DEPTH, 8: event queue depth (power of 2)
- CNT_W, 16: width of the delay, pulse-width and prescale counters
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe (read has no side effects)
- writedata  in  32  write data
- readdata  out  32  combinational read data, zero wait states, zero latency; unused bits and unmapped addresses return 0
- out_port  out  NUM_CH  drum drive outputs, registered
- irq  out  1  level interrupt, registered

## Operation
- Registers:
  - 0 CTRL (RW): [0] enable, [2] irq_en. Bit [1] flush is write-only and self-clearing; it reads 0.
  - 1 STATUS: [3:0] fifo level (RO), [8] empty (RO), [9] full (RO), [10] busy (RO, state≠IDLE), [11] overflow (sticky, W1C), [12] done (sticky, W1C).
  - 2 WIDTH (RW): [CNT_W-1:0] pulse width in ticks; 0 is treated as 1.
  - 3 EVENT (WO): [NUM_CH-1:0] mask, [31:16] delay in ticks. Each write pushes one entry; it reads 0.
  - 4 PRESCALE (RW): [CNT_W-1:0] P; one tick = P+1 clk cycles.
- Reset values: all registers 0, FIFO empty, state IDLE, out_port 0, irq 0.
- FSM: IDLE, WAIT, FIRE.
  - IDLE: when enable=1 and FIFO not empty, pop the head and load the delay counter. Delay 0 goes directly to FIRE. Otherwise go to WAIT.
  - WAIT: the delay counter decrements on each tick. When it reaches 0, go to FIRE.
  - FIRE: out_port = mask, width counter = max(WIDTH,1), decrements on each tick. When it reaches 0, out_port = 0 and go to IDLE. If the FIFO is empty at that moment, set done.
- Prescaler: cleared on every entry to WAIT or FIRE. A tick fires when the count equals P. The prescaler is idle in IDLE.
- WIDTH and PRESCALE are sampled when FIRE and WAIT are entered; mid-event writes affect the next event only.
- Push while full: the entry is dropped and overflow is set. A push and a pop in the same cycle while full is accepted.
- A mask of 0 is legal: it is a timed silent gap.
- enable cleared mid-event: the current event completes; no further pops occur.
- Flush: next cycle, FIFO emptied, state IDLE, out_port 0, counters cleared. done is not set. Flush has priority over a same-cycle EVENT push, which is dropped without setting overflow.
- irq = irq_en & done, registered.

## Timing
- EVENT write in cycle N: level updates at N+1. The pop occurs at N+1 if the block is IDLE and enabled. State and out_port change at N+2.
- Delay D≥1: out_port asserts D·(P+1) cycles after WAIT is entered.
- Pulse: out_port is high for exactly max(WIDTH,1)·(P+1) cycles.
- Back-to-back events with delay 0: one IDLE cycle between pulses, so out_port is 0 for exactly 1 cycle.
- irq rises 1 cycle after done sets. It falls 1 cycle after a W1C write or after irq_en is cleared.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous).

## Structure
- Package drum_sched_pkg holds:
  - register address constants
  - STATUS and CTRL bit positions
  - the state enum {IDLE, WAIT, FIRE}
  - the event entry struct {delay[15:0], mask[NUM_CH-1:0]}
- Sub-module drum_event_fifo: synchronous FIFO with push, pop, flush, level, full and empty outputs, and show-ahead head data.
- The top level holds the register file, prescaler, FSM and output/irq registers.

## Test plan
- Reset: STATUS reads 0x100; out_port=0, irq=0; all other registers read 0.
- P=0, WIDTH=3, enable, EVENT mask=0x05 delay=0: out_port=0x05 for exactly 3 cycles starting at N+2, then 0. STATUS done=1.
- P=9, WIDTH=2, events (0x01,d=5) then (0x20,d=0): out_port=0x01 after 50 cycles in WAIT, high 20 cycles. One zero cycle, then 0x20 for 20 cycles.
- Disabled, 9 EVENT writes: level=8, full=1, overflow=1. W1C on overflow clears it; level stays 8.
- Flush during FIRE with 3 events queued: out_port=0 next cycle, level=0, busy=0, done=0.
- irq_en=1, single event: irq asserts 1 cycle after the pulse ends. Writing STATUS bit12 clears irq the next cycle. With WIDTH=0, the pulse lasts 1 tick.
